tile_scheduler: RTL and testbench

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler_pkg.sv | 33 +++
 rtl/tile_count_calc.sv | 42 ++++
 rtl/tile_scheduler.sv | 129 ++++++++++++
 tb/tb_tile_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared types and widths for the tile scheduler.
//   state_t : scheduler FSM states
//   cfg_t   : layer configuration latched on start
//   *_W     : config field and counter widths
package tile_scheduler_pkg;

  localparam int IFM_W   = 9;
  localparam int CH_W    = 11;
  localparam int K_W     = 2;
  localparam int NF_W    = 11;
  localparam int CNT_F_W = 8;
  localparam int CNT_T_W = 16;
  localparam int PIX_W   = 18;
  localparam int FBASE_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    LOAD_WGT,
    RUN_TILE,
    WAIT_TILE,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [IFM_W-1:0] ifm_size;
    logic [CH_W-1:0]  ifm_channel;
    logic [K_W-1:0]   kernel_size;
    logic [NF_W-1:0]  num_filter;
  } cfg_t;

endpackage

// File: rtl/tile_count_calc.sv
// Combinational layer-geometry calculator.
//   cfg             : latched layer configuration
//   num_load_filter : filter groups of SYSTOLIC_SIZE filters (rounded up)
//   num_tiling      : ceil(ofm_conv^2 / SYSTOLIC_SIZE)
//   empty           : layer has no work (no filters or no output pixels)
module tile_count_calc
  import tile_scheduler_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16
) (
  input  cfg_t               cfg,
  output logic [CNT_F_W-1:0] num_load_filter,
  output logic [CNT_T_W-1:0] num_tiling,
  output logic               empty
);

  localparam int LOG2 = $clog2(SYSTOLIC_SIZE);

  logic signed [9:0] ofm_conv;
  logic [9:0]        ofm_mag;
  logic [PIX_W-1:0]  ofm_sq;
  logic [PIX_W-1:0]  sq_round;
  logic [NF_W:0]     nf_round;
  logic              unused_ch;

  // Channel count does not affect the schedule; it is latched for the datapath only.
  assign unused_ch = ^cfg.ifm_channel;

  assign ofm_conv = $signed({1'b0, cfg.ifm_size}) - $signed({8'b0, cfg.kernel_size}) + 10'sd1;

  // Square the magnitude so a negative ofm still yields the mathematical square.
  assign ofm_mag  = ofm_conv[9] ? $unsigned(-ofm_conv) : $unsigned(ofm_conv);
  assign ofm_sq   = PIX_W'(ofm_mag * ofm_mag);
  assign sq_round = ofm_sq + PIX_W'(SYSTOLIC_SIZE - 1);
  assign num_tiling = CNT_T_W'(sq_round >> LOG2);

  assign nf_round = {1'b0, cfg.num_filter} + (NF_W + 1)'(SYSTOLIC_SIZE - 1);
  assign num_load_filter = CNT_F_W'(nf_round >> LOG2);

  assign empty = (cfg.num_filter == '0) || (ofm_conv <= 10'sd0);

endmodule

// File: rtl/tile_scheduler.sv
// Layer scheduler for a systolic array: loads each filter group, then launches
// every output-pixel tile for that group, walking filters in the outer loop.
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : layer start (honoured in IDLE/DONE only)
//   ifm_size..num_filter        : layer config, latched on start
//   wgt_load_req/wgt_load_done  : filter-group load handshake
//   tile_start/tile_done        : tile launch pulse and completion
//   count_*/num_*               : loop counters and their limits
//   filter_base, pixel_base     : counters scaled by SYSTOLIC_SIZE
//   busy, done                  : layer in progress / layer complete
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IFM_W-1:0]   ifm_size,
  input  logic [CH_W-1:0]    ifm_channel,
  input  logic [K_W-1:0]     kernel_size,
  input  logic [NF_W-1:0]    num_filter,
  output logic               wgt_load_req,
  input  logic               wgt_load_done,
  output logic               tile_start,
  input  logic               tile_done,
  output logic [CNT_F_W-1:0] count_filter,
  output logic [CNT_F_W-1:0] num_load_filter,
  output logic [CNT_T_W-1:0] count_tiling,
  output logic [CNT_T_W-1:0] num_tiling,
  output logic [FBASE_W-1:0] filter_base,
  output logic [PIX_W-1:0]   pixel_base,
  output logic               busy,
  output logic               done
);

  localparam int LOG2 = $clog2(SYSTOLIC_SIZE);

  state_t             state, state_n;
  cfg_t               cfg;
  logic [CNT_F_W-1:0] calc_nlf;
  logic [CNT_T_W-1:0] calc_nt;
  logic               calc_empty;
  logic               tile_more;
  logic               filter_more;

  tile_count_calc #(.SYSTOLIC_SIZE(SYSTOLIC_SIZE)) u_calc (
    .cfg             (cfg),
    .num_load_filter (calc_nlf),
    .num_tiling      (calc_nt),
    .empty           (calc_empty)
  );

  // Compare with +1 on the counter instead of -1 on the limit to avoid underflow.
  assign tile_more   = ({1'b0, count_tiling} + 17'd1) < {1'b0, num_tiling};
  assign filter_more = ({1'b0, count_filter} + 9'd1)  < {1'b0, num_load_filter};

  assign filter_base = FBASE_W'(count_filter) << LOG2;
  assign pixel_base  = PIX_W'(count_tiling) << LOG2;

  always_comb begin
    state_n      = state;
    wgt_load_req = 1'b0;
    tile_start   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = CALC;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = CALC;
      end
      CALC:      state_n = calc_empty ? DONE : LOAD_WGT;
      LOAD_WGT: begin
        wgt_load_req = 1'b1;
        if (wgt_load_done) state_n = RUN_TILE;
      end
      RUN_TILE: begin
        tile_start = 1'b1;
        state_n    = WAIT_TILE;
      end
      WAIT_TILE: if (tile_done) state_n = NEXT;
      NEXT: begin
        if (tile_more)        state_n = RUN_TILE;
        else if (filter_more) state_n = LOAD_WGT;
        else                  state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cfg             <= '0;
      count_filter    <= '0;
      count_tiling    <= '0;
      num_load_filter <= '0;
      num_tiling      <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: begin
          if (start) cfg <= '{ifm_size, ifm_channel, kernel_size, num_filter};
        end
        CALC: begin
          num_load_filter <= calc_nlf;
          num_tiling      <= calc_nt;
          count_filter    <= '0;
          count_tiling    <= '0;
        end
        NEXT: begin
          if (tile_more) begin
            count_tiling <= count_tiling + 1'b1;
          end else if (filter_more) begin
            count_tiling <= '0;
            count_filter <= count_filter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

  localparam int SS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  ifm_size;
  logic [10:0] ifm_channel;
  logic [1:0]  kernel_size;
  logic [10:0] num_filter;
  logic        wgt_load_req;
  logic        wgt_load_done;
  logic        tile_start;
  logic        tile_done;
  logic [7:0]  count_filter;
  logic [7:0]  num_load_filter;
  logic [15:0] count_tiling;
  logic [15:0] num_tiling;
  logic [10:0] filter_base;
  logic [17:0] pixel_base;
  logic        busy;
  logic        done;

  tile_scheduler #(.SYSTOLIC_SIZE(SS)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .ifm_size        (ifm_size),
    .ifm_channel     (ifm_channel),
    .kernel_size     (kernel_size),
    .num_filter      (num_filter),
    .wgt_load_req    (wgt_load_req),
    .wgt_load_done   (wgt_load_done),
    .tile_start      (tile_start),
    .tile_done       (tile_done),
    .count_filter    (count_filter),
    .num_load_filter (num_load_filter),
    .count_tiling    (count_tiling),
    .num_tiling      (num_tiling),
    .filter_base     (filter_base),
    .pixel_base      (pixel_base),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ifm, ch, k, nf;
    int nlf, nt, loads, tiles;
    bit zero_lat, inj_start;
  } vec_t;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"},   int'(wgt_load_req), 0);
    chk({tag, "_ts"},    int'(tile_start), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_cf"},    int'(count_filter), 0);
    chk({tag, "_ct"},    int'(count_tiling), 0);
    chk({tag, "_nlf"},   int'(num_load_filter), 0);
    chk({tag, "_nt"},    int'(num_tiling), 0);
    chk({tag, "_fbase"}, int'(filter_base), 0);
    chk({tag, "_pbase"}, int'(pixel_base), 0);
  endtask

  // Reference: schedule is a nested loop of nlf filter groups x nt tiles.
  function automatic vec_t model(input int ifm, input int k, input int nf);
    vec_t v;
    int ofm;
    ofm = ifm - k + 1;
    v.ifm = ifm; v.ch = 8; v.k = k; v.nf = nf;
    v.nlf = (nf + SS - 1) / SS;
    v.nt  = (ofm * ofm + SS - 1) / SS;
    if (nf == 0 || ofm <= 0) begin
      v.loads = 0; v.tiles = 0;
    end else begin
      v.loads = v.nlf; v.tiles = v.nlf * v.nt;
    end
    v.zero_lat = 1'b0; v.inj_start = 1'b0;
    return v;
  endfunction

  task automatic run_layer(input vec_t v);
    int  loads, tiles, cyc, last_pb;
    bit  prev_req, prev_ts, fin, dbl;
    loads = 0; tiles = 0; cyc = 0; last_pb = 0;
    prev_req = 0; prev_ts = 0; fin = 0; dbl = 0;
    @(negedge clk);
    ifm_size = 9'(v.ifm); ifm_channel = 11'(v.ch);
    kernel_size = 2'(v.k); num_filter = 11'(v.nf);
    start = 1; wgt_load_done = 0; tile_done = 0;
    @(negedge clk);
    start = 0;
    // Config must already be latched; scramble it for the rest of the layer.
    ifm_size = 9'($urandom); ifm_channel = 11'($urandom);
    kernel_size = 2'($urandom); num_filter = 11'($urandom);
    chk("busy_after_start", int'(busy), 1);
    chk("done_cleared", int'(done), 0);
    @(negedge clk);
    if (v.tiles == 0) chk("empty_done_latency", int'(done), 1);
    else              chk("req_latency", int'(wgt_load_req), 1);
    while (!fin && cyc < 5000) begin
      if (done) fin = 1;
      if (wgt_load_req && !prev_req) loads++;
      if (tile_start) begin
        if (prev_ts) dbl = 1;
        if (v.nt > 0) begin
          chk("count_filter", int'(count_filter), tiles / v.nt);
          chk("count_tiling", int'(count_tiling), tiles % v.nt);
          chk("filter_base", int'(filter_base), (tiles / v.nt) * SS);
          chk("pixel_base", int'(pixel_base), (tiles % v.nt) * SS);
        end
        last_pb = int'(pixel_base);
        tiles++;
      end
      start = (v.inj_start && tiles == 6 && prev_ts && !tile_start);
      wgt_load_done = v.zero_lat ? 1'b1 : ($urandom_range(0, 2) == 0);
      tile_done     = v.zero_lat ? 1'b1 : ($urandom_range(0, 2) == 0);
      prev_req = wgt_load_req;
      prev_ts  = tile_start;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    chk("layer_finished", int'(fin), 1);
    chk("tile_start_single", int'(dbl), 0);
    chk("wgt_loads", loads, v.loads);
    chk("tile_starts", tiles, v.tiles);
    chk("num_load_filter", int'(num_load_filter), v.nlf);
    chk("num_tiling", int'(num_tiling), v.nt);
    chk("busy_at_done", int'(busy), 0);
    if (v.tiles > 0) chk("last_pixel_base", last_pb, (v.nt - 1) * SS);
    wgt_load_done = 0; tile_done = 0;
    @(negedge clk);
    chk("done_hold", int'(done), 1);
  endtask

  vec_t tbl[8];

  initial begin
    int   n, cyc;
    bit   issued;
    vec_t rv;

    tbl[0] = '{13, 32, 1, 16, 1, 11, 1, 11, 1'b0, 1'b0};
    tbl[1] = '{13, 32, 1, 40, 3, 11, 3, 33, 1'b0, 1'b0};
    tbl[2] = '{ 2,  8, 3, 16, 1,  0, 0,  0, 1'b0, 1'b0};
    tbl[3] = '{13,  8, 1,  0, 0, 11, 0,  0, 1'b0, 1'b0};
    tbl[4] = '{ 4,  8, 3, 17, 2,  1, 2,  2, 1'b0, 1'b0};
    tbl[5] = '{ 5,  8, 0,  1, 1,  3, 1,  3, 1'b0, 1'b0};
    tbl[6] = '{13, 32, 1, 16, 1, 11, 1, 11, 1'b1, 1'b1};
    tbl[7] = '{ 1,  8, 3,  5, 1,  1, 0,  0, 1'b0, 1'b0};

    rst = 1; start = 0; wgt_load_done = 0; tile_done = 0;
    ifm_size = 0; ifm_channel = 0; kernel_size = 0; num_filter = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;

    for (int i = 0; i < 8; i++) run_layer(tbl[i]);

    // Reset while waiting on tile 5 abandons the layer.
    @(negedge clk);
    ifm_size = 13; ifm_channel = 32; kernel_size = 1; num_filter = 16;
    start = 1; wgt_load_done = 1; tile_done = 1;
    @(negedge clk);
    start = 0;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (tile_start) n++;
    end
    tile_done = 0;
    chk("rst_seq_reach_tile5", n, 6);
    @(negedge clk);
    chk("rst_seq_ct_before", int'(count_tiling), 5);
    chk("rst_seq_busy_before", int'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_idle("midlayer_rst");
    wgt_load_done = 1; tile_done = 1; issued = 0;
    repeat (10) begin
      @(negedge clk);
      if (wgt_load_req || tile_start || busy || done) issued = 1;
    end
    chk("no_issue_after_rst", int'(issued), 0);
    run_layer(tbl[0]);

    for (int i = 0; i < 6; i++) begin
      rv = model($urandom_range(3, 20), $urandom_range(0, 3), $urandom_range(0, 50));
      run_layer(rv);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
